// File: rtl/di_pkg.sv
// Shared constants and FSM state type for the DI terminal router.
package di_pkg;

   localparam logic [15:0] DI_STATUS_OK      = 16'h0000;
   localparam logic [15:0] DI_STATUS_NOTERM  = 16'hFFFF;
   localparam logic [15:0] DI_STATUS_TIMEOUT = 16'hFFFE;
   localparam logic [15:0] DI_FILL_NOTERM    = 16'hAAAA;
   localparam logic [15:0] DI_FILL_TIMEOUT   = 16'hDEAD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_TMO  = 2'd3
   } di_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/di_term_router_if.sv
// Host-side DI bus: transfer modes, per-word strobes, and ready/data/status back.
// Handshake: a word moves in a cycle where the host raises di_read (or di_write)
// while the matching di_*_rdy is high; di_read_req marks the start of a read word.
interface di_term_router_if;

   logic [15:0] di_term_addr;
   logic        di_read_mode;
   logic        di_write_mode;
   logic        di_read_req;
   logic        di_read;
   logic        di_write;
   logic        di_read_rdy;
   logic        di_write_rdy;
   logic [15:0] di_reg_datao;
   logic [15:0] di_transfer_status;

   modport master (
      output di_term_addr, di_read_mode, di_write_mode,
      output di_read_req, di_read, di_write,
      input  di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status
   );

   modport slave (
      input  di_term_addr, di_read_mode, di_write_mode,
      input  di_read_req, di_read, di_write,
      output di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status
   );

endinterface

// File: rtl/di_term_decode.sv
// Address decode and zero-latency terminal mux; lowest matching slot wins.
module di_term_decode
   import di_pkg::*;
#(
   parameter int unsigned              NUM_TERMS  = 4,
   parameter logic [NUM_TERMS*16-1:0]  TERM_ADDRS = {16'd3, 16'd2, 16'd1, 16'd0}
) (
   input  logic [15:0]             addr,
   input  logic                    force_tmo,
   input  logic [NUM_TERMS-1:0]    term_read_rdy,
   input  logic [NUM_TERMS-1:0]    term_write_rdy,
   input  logic [NUM_TERMS*16-1:0] term_datao,
   input  logic [NUM_TERMS*16-1:0] term_status,
   output logic [NUM_TERMS-1:0]    term_sel,
   output logic                    read_rdy,
   output logic                    write_rdy,
   output logic [15:0]             datao,
   output logic [15:0]             status
);

   logic hit;

   always_comb begin
      hit       = 1'b0;
      term_sel  = '0;
      read_rdy  = 1'b1;
      write_rdy = 1'b1;
      datao     = DI_FILL_NOTERM;
      status    = DI_STATUS_NOTERM;
      for (int i = 0; i < NUM_TERMS; i++) begin
         if (!hit && (addr == TERM_ADDRS[16*i +: 16])) begin
            hit         = 1'b1;
            term_sel[i] = 1'b1;
            read_rdy    = term_read_rdy[i];
            write_rdy   = term_write_rdy[i];
            datao       = term_datao[16*i +: 16];
            status      = term_status[16*i +: 16];
         end
      end
      // A timed-out transfer detaches the terminal and keeps the host moving.
      if (force_tmo) begin
         term_sel  = '0;
         read_rdy  = 1'b1;
         write_rdy = 1'b1;
         datao     = DI_FILL_TIMEOUT;
         status    = DI_STATUS_TIMEOUT;
      end
   end

endmodule

// File: rtl/di_term_router.sv
// DI terminal router: transfer FSM, word counter and optional stall timeout
// (enabled by defining DI_TERM_ROUTER_TIMEOUT_EN).
module di_term_router
   import di_pkg::*;
#(
   parameter int unsigned              NUM_TERMS      = 4,
   parameter logic [NUM_TERMS*16-1:0]  TERM_ADDRS     = {16'd3, 16'd2, 16'd1, 16'd0},
   parameter int unsigned              TIMEOUT_CYCLES = 1024
) (
   input  logic                    ifclk,
   input  logic                    resetb,
   di_term_router_if.slave         host,
   output logic [NUM_TERMS-1:0]    term_sel,
   input  logic [NUM_TERMS-1:0]    term_read_rdy,
   input  logic [NUM_TERMS-1:0]    term_write_rdy,
   input  logic [NUM_TERMS*16-1:0] term_datao,
   input  logic [NUM_TERMS*16-1:0] term_status,
   output logic [31:0]             xfer_words,
   output logic                    timeout_flag,
   output di_state_e               dbg_state
);

   di_state_e   state_q, state_d;
   logic [31:0] xfer_words_q, xfer_words_d;
   logic        sel_rd_rdy, sel_wr_rdy;
   logic        force_tmo;
   logic        start_xfer;
   logic        stall_expired;
   logic        tmo_mode_active;

   // Overrides are suppressed while reset is held so outputs stay pass-through.
   assign force_tmo = resetb && (state_q == ST_TMO);

   di_term_decode #(
      .NUM_TERMS  (NUM_TERMS),
      .TERM_ADDRS (TERM_ADDRS)
   ) u_decode (
      .addr           (host.di_term_addr),
      .force_tmo      (force_tmo),
      .term_read_rdy  (term_read_rdy),
      .term_write_rdy (term_write_rdy),
      .term_datao     (term_datao),
      .term_status    (term_status),
      .term_sel       (term_sel),
      .read_rdy       (sel_rd_rdy),
      .write_rdy      (sel_wr_rdy),
      .datao          (host.di_reg_datao),
      .status         (host.di_transfer_status)
   );

   assign host.di_read_rdy  = sel_rd_rdy;
   assign host.di_write_rdy = sel_wr_rdy;

   assign start_xfer = (state_q == ST_IDLE) && (host.di_read_mode || host.di_write_mode);

`ifdef DI_TERM_ROUTER_TIMEOUT_EN
   localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] stall_q, stall_d;
   logic        tmo_rd_q, tmo_rd_d;
   logic        timeout_flag_q, timeout_flag_d;
   logic        in_xfer, cur_rdy, word_strobe;

   assign in_xfer         = (state_q == ST_RD) || (state_q == ST_WR);
   assign cur_rdy         = (state_q == ST_RD) ? sel_rd_rdy : sel_wr_rdy;
   assign word_strobe     = host.di_read_req || host.di_write;
   assign stall_expired   = in_xfer && !cur_rdy && !word_strobe && (stall_q >= STALL_LIMIT);
   assign tmo_mode_active = tmo_rd_q ? host.di_read_mode : host.di_write_mode;

   always_comb begin
      stall_d        = stall_q;
      tmo_rd_d       = tmo_rd_q;
      timeout_flag_d = timeout_flag_q;
      if (start_xfer) begin
         stall_d        = 16'd0;
         tmo_rd_d       = host.di_read_mode;
         timeout_flag_d = 1'b0;
      end else begin
         if (word_strobe) begin
            stall_d = 16'd0;
         end else if (in_xfer && !cur_rdy) begin
            stall_d = sat_inc16(stall_q);
         end
         if ((state_d == ST_TMO) && (state_q != ST_TMO)) begin
            timeout_flag_d = 1'b1;
         end
      end
   end

   always_ff @(posedge ifclk) begin
      if (!resetb) begin
         stall_q        <= 16'd0;
         tmo_rd_q       <= 1'b0;
         timeout_flag_q <= 1'b0;
      end else begin
         stall_q        <= stall_d;
         tmo_rd_q       <= tmo_rd_d;
         timeout_flag_q <= timeout_flag_d;
      end
   end

   assign timeout_flag = timeout_flag_q;
`else
   assign stall_expired   = 1'b0;
   assign tmo_mode_active = 1'b0;
   assign timeout_flag    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (host.di_read_mode) begin
               state_d = ST_RD;
            end else if (host.di_write_mode) begin
               state_d = ST_WR;
            end
         end
         ST_RD: begin
            if (!host.di_read_mode) begin
               state_d = ST_IDLE;
            end else if (stall_expired) begin
               state_d = ST_TMO;
            end
         end
         ST_WR: begin
            if (!host.di_write_mode) begin
               state_d = ST_IDLE;
            end else if (stall_expired) begin
               state_d = ST_TMO;
            end
         end
         ST_TMO: begin
            if (!tmo_mode_active) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      xfer_words_d = xfer_words_q;
      if (start_xfer) begin
         xfer_words_d = 32'd0;
      end else if (((state_q == ST_RD) && host.di_read) ||
                   ((state_q == ST_WR) && host.di_write)) begin
         xfer_words_d = xfer_words_q + 32'd1;
      end
   end

   always_ff @(posedge ifclk) begin
      if (!resetb) begin
         state_q      <= ST_IDLE;
         xfer_words_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         xfer_words_q <= xfer_words_d;
      end
   end

   assign xfer_words = xfer_words_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_di_term_router.sv
// Directed bench for di_term_router: stimulus pushes expected responses, a
// negedge monitor pops and compares whenever a strobe or probe is presented.
module tb_di_term_router;
   import di_pkg::*;

   localparam int NT = 4;

   logic ifclk;
   logic resetb;
   logic [NT-1:0]    term_sel;
   logic [NT-1:0]    term_read_rdy;
   logic [NT-1:0]    term_write_rdy;
   logic [NT*16-1:0] term_datao;
   logic [NT*16-1:0] term_status;
   logic [31:0]      xfer_words;
   logic             timeout_flag;
   di_state_e        dbg_state;
   logic             probe;

   di_term_router_if host ();

   di_term_router #(
      .NUM_TERMS      (NT),
      .TERM_ADDRS     ({16'd3, 16'd2, 16'd1, 16'd0}),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .ifclk          (ifclk),
      .resetb         (resetb),
      .host           (host),
      .term_sel       (term_sel),
      .term_read_rdy  (term_read_rdy),
      .term_write_rdy (term_write_rdy),
      .term_datao     (term_datao),
      .term_status    (term_status),
      .xfer_words     (xfer_words),
      .timeout_flag   (timeout_flag),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial ifclk = 1'b0;
   always #5 ifclk = ~ifclk;

   // scoreboard state: word = {datao, status, rd_rdy, wr_rdy, term_sel}
   // probe = {xfer_words, timeout_flag, state}
   logic [37:0] word_q[$];
   logic [34:0] prb_q[$];
   string       wname_q[$];
   string       pname_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;

   function automatic logic [37:0] w(input logic [15:0] d, input logic [15:0] s,
                                     input logic rr, input logic wr, input logic [3:0] sel);
      return {d, s, rr, wr, sel};
   endfunction

   function automatic logic [34:0] p(input logic [31:0] xw, input logic tf, input di_state_e st);
      return {xw, tf, 2'(st)};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge ifclk);
      #1;
   endtask

   task automatic do_read(input string nm, input logic [37:0] exp);
      word_q.push_back(exp);
      wname_q.push_back(nm);
      host.di_read = 1'b1;
      host.di_read_req = 1'b1;
      tick();
      host.di_read = 1'b0;
      host.di_read_req = 1'b0;
   endtask

   task automatic do_req(input string nm, input logic [37:0] exp);
      word_q.push_back(exp);
      wname_q.push_back(nm);
      host.di_read_req = 1'b1;
      tick();
      host.di_read_req = 1'b0;
   endtask

   task automatic do_write(input string nm, input logic [37:0] exp);
      word_q.push_back(exp);
      wname_q.push_back(nm);
      host.di_write = 1'b1;
      tick();
      host.di_write = 1'b0;
   endtask

   task automatic do_probe(input string nm, input logic [34:0] exp);
      prb_q.push_back(exp);
      pname_q.push_back(nm);
      probe = 1'b1;
      tick();
      probe = 1'b0;
   endtask

   // monitor
   always @(negedge ifclk) begin
      logic [37:0] act_w, exp_w;
      logic [34:0] act_p, exp_p;
      string nm;
      if (host.di_read || host.di_write || host.di_read_req) begin
         act_w = {host.di_reg_datao, host.di_transfer_status, host.di_read_rdy,
                  host.di_write_rdy, term_sel};
         n_cmp++;
         if (word_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word actual=%h (no expectation queued)", act_w);
         end else begin
            exp_w = word_q.pop_front();
            nm = wname_q.pop_front();
            if (act_w !== exp_w) begin
               n_fail++;
               $display("FAIL %s actual=%h required=%h", nm, act_w, exp_w);
            end
         end
      end
      if (probe) begin
         act_p = {xfer_words, timeout_flag, 2'(dbg_state)};
         n_cmp++;
         if (prb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_probe actual=%h (no expectation queued)", act_p);
         end else begin
            exp_p = prb_q.pop_front();
            nm = pname_q.pop_front();
            if (act_p !== exp_p) begin
               n_fail++;
               $display("FAIL %s actual=%h required=%h (xfer,flag,state)", nm, act_p, exp_p);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      n_fail++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

   // directed stimulus
   initial begin
      resetb = 1'b0;
      probe = 1'b0;
      host.di_term_addr = 16'd1;
      host.di_read_mode = 1'b0;
      host.di_write_mode = 1'b0;
      host.di_read_req = 1'b0;
      host.di_read = 1'b0;
      host.di_write = 1'b0;
      term_read_rdy = '1;
      term_write_rdy = '1;
      term_datao = {16'h3333, 16'h2222, 16'h1234, 16'h1000};
      term_status = {16'h0303, 16'h0202, 16'h0000, 16'h0100};
      tick();
      tick();

      // reset state and pass-through during reset
      do_read("reset_passthru", w(16'h1234, 16'h0000, 1'b1, 1'b1, 4'b0010));
      do_probe("reset_state", p(32'd0, 1'b0, ST_IDLE));
      resetb = 1'b1;
      tick();

      // 8-word read from slot 1
      host.di_read_mode = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         do_read($sformatf("slot1_read_%0d", i), w(16'h1234, 16'h0000, 1'b1, 1'b1, 4'b0010));
      end
      do_probe("slot1_read_count", p(32'd8, 1'b0, ST_RD));
      host.di_read_mode = 1'b0;
      tick();
      do_probe("slot1_read_idle", p(32'd8, 1'b0, ST_IDLE));

      // unmatched address
      host.di_term_addr = 16'h00FF;
      host.di_read_mode = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         do_read($sformatf("noterm_read_%0d", i), w(16'hAAAA, 16'hFFFF, 1'b1, 1'b1, 4'b0000));
      end
      do_probe("noterm_count", p(32'd4, 1'b0, ST_RD));
      host.di_read_mode = 1'b0;
      tick();

      // slot 0 writes with 10-cycle ready gaps
      host.di_term_addr = 16'd0;
      host.di_write_mode = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         do_write($sformatf("slot0_write_%0d", i), w(16'h1000, 16'h0100, 1'b1, 1'b1, 4'b0001));
         term_write_rdy[0] = 1'b0;
         repeat (10) tick();
         term_write_rdy[0] = 1'b1;
      end
      do_probe("slot0_write_count", p(32'd5, 1'b0, ST_WR));
      host.di_write_mode = 1'b0;
      tick();

      // reset mid-read
      host.di_term_addr = 16'd1;
      host.di_read_mode = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         do_read($sformatf("pre_reset_read_%0d", i), w(16'h1234, 16'h0000, 1'b1, 1'b1, 4'b0010));
      end
      do_probe("pre_reset_count", p(32'd3, 1'b0, ST_RD));
      resetb = 1'b0;
      tick();
      resetb = 1'b1;
      do_probe("post_reset_state", p(32'd0, 1'b0, ST_IDLE));
      do_probe("post_reset_restart", p(32'd0, 1'b0, ST_RD));
      host.di_read_mode = 1'b0;
      tick();

`ifdef DI_TERM_ROUTER_TIMEOUT_EN
      // stuck read on slot 2: TMO after the 16th stall cycle
      host.di_term_addr = 16'd2;
      term_read_rdy[2] = 1'b0;
      host.di_read_mode = 1'b1;
      tick();
      repeat (14) tick();
      do_probe("stall_cycle_15", p(32'd0, 1'b0, ST_RD));
      do_probe("stall_cycle_16", p(32'd0, 1'b0, ST_RD));
      do_probe("tmo_entry", p(32'd0, 1'b1, ST_TMO));
      do_read("tmo_word", w(16'hDEAD, 16'hFFFE, 1'b1, 1'b1, 4'b0000));
      do_probe("tmo_no_count", p(32'd0, 1'b1, ST_TMO));
      host.di_read_mode = 1'b0;
      tick();
      do_probe("tmo_flag_sticky", p(32'd0, 1'b1, ST_IDLE));
      host.di_term_addr = 16'd0;
      host.di_write_mode = 1'b1;
      tick();
      do_probe("tmo_flag_clear", p(32'd0, 1'b0, ST_WR));
      host.di_write_mode = 1'b0;
      tick();

      // read_req clears the stall count
      host.di_term_addr = 16'd2;
      host.di_read_mode = 1'b1;
      tick();
      repeat (10) tick();
      do_read("stall_req_word", w(16'h2222, 16'h0202, 1'b0, 1'b1, 4'b0100));
      repeat (14) tick();
      do_probe("stall_clr_c26", p(32'd1, 1'b0, ST_RD));
      do_probe("stall_clr_c27", p(32'd1, 1'b0, ST_RD));
      do_probe("stall_clr_tmo", p(32'd1, 1'b1, ST_TMO));
      host.di_read_mode = 1'b0;
      tick();

      // abandon mid-stall
      host.di_read_mode = 1'b1;
      tick();
      repeat (5) tick();
      host.di_read_mode = 1'b0;
      tick();
      do_probe("abandon_no_flag", p(32'd0, 1'b0, ST_IDLE));
      term_read_rdy[2] = 1'b1;
`else
      // stuck read with timeout disabled
      host.di_term_addr = 16'd2;
      term_read_rdy[2] = 1'b0;
      host.di_read_mode = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         repeat (999) tick();
         do_probe($sformatf("stuck_%0d", i), p(32'd0, 1'b0, ST_RD));
      end
      do_req("stuck_word", w(16'h2222, 16'h0202, 1'b0, 1'b1, 4'b0100));
      host.di_read_mode = 1'b0;
      tick();
      term_read_rdy[2] = 1'b1;
`endif

      repeat (3) tick();
      if (word_q.size() != 0 || prb_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_expectations actual=%0d required=0",
                  word_q.size() + prb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/di_term_router.md
DI_TERM_ROUTER -- requirements
Module: di_term_router

Interface
REQ-001 SHALL have parameter NUM_TERMS, default 4, number of attached terminals (1..8).
REQ-002 SHALL have parameter TERM_ADDRS, default {16'd3,16'd2,16'd1,16'd0}, packed NUM_TERMS x 16 terminal addresses, slot i at bits [16i+15:16i].
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall limit per word (2..65535).
REQ-004 ifclk  in  1  clock; resetb  in  1  reset, synchronous, active-low.
REQ-005 di_term_addr  in  16  terminal address of the current transfer.
REQ-006 di_read_mode / di_write_mode  in  1 each  transfer in progress.
REQ-007 di_read_req / di_read / di_write  in  1 each  per-word strobes from the host interface.
REQ-008 di_read_rdy / di_write_rdy  out  1 each  ready back to the host interface.
REQ-009 di_reg_datao  out  16  read data; di_transfer_status  out  16  status word.
REQ-010 term_sel  out  NUM_TERMS  one-hot selected terminal, zero if none.
REQ-011 term_read_rdy / term_write_rdy  in  NUM_TERMS each; term_datao / term_status  in  NUM_TERMS x 16 each.
REQ-012 xfer_words  out  32  words completed in the current transfer; timeout_flag  out  1  sticky timeout indication.

Function
REQ-013 SHALL decode term_sel combinationally as di_term_addr == TERM_ADDRS slot i; the lowest slot wins on duplicates.
REQ-014 Selected, no timeout: rdy, datao and status SHALL pass through from the selected slot with zero latency.
REQ-015 No match: di_reg_datao = 16'hAAAA, both rdy = 1, status = 16'hFFFF.
REQ-016 FSM states SHALL be IDLE, RD, WR, TMO; reset state IDLE.
REQ-017 IDLE->RD on di_read_mode; IDLE->WR on di_write_mode; read_mode wins if both are asserted.
REQ-018 RD/WR/TMO SHALL return to IDLE in the cycle after their mode input deasserts.
REQ-019 Stall counter (16b) SHALL clear on entry to RD/WR and on every di_read_req/di_write.
REQ-020 The stall counter SHALL increment each RD/WR cycle in which the selected rdy is 0, and SHALL saturate.
REQ-021 When the stall count reaches TIMEOUT_CYCLES-1 with rdy still 0, the FSM SHALL go to TMO on the next edge.
REQ-022 In TMO: both rdy = 1, di_reg_datao = 16'hDEAD, status = 16'hFFFE, term_sel forced to 0.
REQ-023 timeout_flag SHALL set on TMO entry and clear only on the next IDLE->RD/WR transition or on reset.
REQ-024 xfer_words SHALL clear on IDLE->RD/WR and increment on each di_read (RD) or di_write (WR), wrapping at 2^32.
REQ-025 Mode deasserting mid-stall SHALL abandon the transfer without setting timeout_flag.

Reset
REQ-026 resetb low at any edge SHALL force IDLE, stall counter 0, xfer_words 0, timeout_flag 0, even mid-transfer.
REQ-027 Combinational outputs SHALL follow REQ-014/015 during reset; TMO overrides SHALL not apply.

Configuration
REQ-028 Macro DI_TERM_ROUTER_TIMEOUT_EN defined: REQ-019..023 apply.
REQ-029 Macro DI_TERM_ROUTER_TIMEOUT_EN undefined: no stall counter, TMO unreachable, timeout_flag tied 0, the FSM still tracks RD/WR for xfer_words, and TIMEOUT_CYCLES is ignored.

Structure
REQ-030 Shared package di_pkg SHALL hold status constants DI_STATUS_OK=0, DI_STATUS_NOTERM=16'hFFFF, DI_STATUS_TIMEOUT=16'hFFFE, fill values 16'hAAAA/16'hDEAD, and the FSM state enum.
REQ-031 Address decode plus mux SHALL be sub-module di_term_decode; the FSM and counters stay in the top module.

Verification
REQ-032 Addr = slot 1, term_datao[1] = 16'h1234, rdy = 1, read of 8 words -> datao 16'h1234 every word, xfer_words = 8, status 0.
REQ-033 Addr 16'h00FF (no match), read 4 words -> datao 16'hAAAA, status 16'hFFFF, rdy high throughout.
REQ-034 TIMEOUT_CYCLES = 16, slot 2 read_rdy stuck at 0 -> TMO on the 16th stall cycle, datao 16'hDEAD, status 16'hFFFE, timeout_flag = 1 until the next transfer starts.
REQ-035 Slot 0 write_rdy low 10 cycles after each di_write, 5 writes, TIMEOUT_CYCLES = 16 -> no timeout, xfer_words = 5.
REQ-036 resetb pulsed low mid-read at xfer_words = 3 -> xfer_words 0, state IDLE, timeout_flag 0 on the following cycle.
REQ-037 Build without DI_TERM_ROUTER_TIMEOUT_EN, stuck read_rdy for 5000 cycles -> di_read_rdy stays 0 and timeout_flag stays 0.
